// File: rtl/mult_sched_if.sv
// ---------------------------------------------------------------------------
// mult_sched_if
//   Bundle of every non-clock signal of mult_sched. It covers the two issue
//   ports (request, operands, grant, done), the shared result registers and
//   the control/data path to the iterative multiplier.
//
//   slave  : view used by mult_sched (the sequencer/arbiter itself)
//   master : view used by its surroundings (issue logic + multiplier)
//
//   Signals
//     req0/req1          level request per port, held until that port's done
//     a0,b0 / a1,b1      32-bit operands per port, sampled at grant
//     gnt0/gnt1          registered grant, grant edge .. capture edge
//     done0/done1        one-cycle completion pulse, result valid in hi/lo
//     busy               sequencer not idle
//     hi/lo              product[63:32] / product[31:0] of last completed op
//     mul_dataA/B        latched operands presented to the multiplier
//     mul_signal         multiplier op-code (MULTU while iterating, else OUT)
//     mul_reset          multiplier product clear
//     mul_product        64-bit multiplier product
// ---------------------------------------------------------------------------
interface mult_sched_if;
    logic        req0;
    logic        req1;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mul_dataA;
    logic [31:0] mul_dataB;
    logic [5:0]  mul_signal;
    logic        mul_reset;
    logic [63:0] mul_product;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, mul_product,
        output gnt0, gnt1, done0, done1, busy, hi, lo,
               mul_dataA, mul_dataB, mul_signal, mul_reset
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, mul_product,
        input  gnt0, gnt1, done0, done1, busy, hi, lo,
               mul_dataA, mul_dataB, mul_signal, mul_reset
    );
endinterface

// File: rtl/mult_sched.sv
// ---------------------------------------------------------------------------
// mult_sched
//   Sequencer and round-robin arbiter sharing one iterative 32x32 unsigned
//   shift-add multiplier between two requesters. The winner's operands are
//   latched, the multiplier is cleared for one cycle and then run for 32
//   MULTU cycles, after which the 64-bit product is captured into hi/lo and
//   a one-cycle done pulse is returned to the granted port.
//
//   Ports
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    mult_sched_if.slave (issue ports, results, multiplier path)
//
//   Optional feature
//     MULT_SCHED_ZERO_BYPASS_EN : when defined, a grant whose selected a or b
//     is zero skips the multiplier entirely and completes with a zero
//     product one edge after the grant.
// ---------------------------------------------------------------------------
module mult_sched (
    input  logic        clk,
    input  logic        reset,
    mult_sched_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_CAPT  = 2'd3;

    localparam logic [5:0] SIG_MULTU = 6'b011001;
    localparam logic [5:0] SIG_OUT   = 6'b111111;

    localparam logic [5:0] LAST_ITER = 6'd31;

    logic [1:0]  state_q,  state_d;
    logic [5:0]  cnt_q,    cnt_d;
    logic        lg_q,     lg_d;
    logic        gnt0_q,   gnt0_d;
    logic        gnt1_q,   gnt1_d;
    logic        done0_q,  done0_d;
    logic        done1_q,  done1_d;
    logic [31:0] hi_q,     hi_d;
    logic [31:0] lo_q,     lo_d;
    logic [31:0] data_a_q, data_a_d;
    logic [31:0] data_b_q, data_b_d;
    logic        zero_q,   zero_d;

    logic        any_req;
    logic        pick1;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic        sel_zero;

    // Round-robin: a lone requester always wins; on a tie the port that
    // did not win last time (lg_q) goes next.
    always_comb begin
        any_req = bus.req0 | bus.req1;
        pick1   = bus.req1 & (~bus.req0 | ~lg_q);
        sel_a   = pick1 ? bus.a1 : bus.a0;
        sel_b   = pick1 ? bus.b1 : bus.b0;
    end

`ifdef MULT_SCHED_ZERO_BYPASS_EN
    assign sel_zero = (sel_a == '0) || (sel_b == '0);
`else
    assign sel_zero = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lg_d     = lg_q;
        gnt0_d   = gnt0_q;
        gnt1_d   = gnt1_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        zero_d   = zero_q;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    gnt0_d   = ~pick1;
                    gnt1_d   = pick1;
                    lg_d     = pick1;
                    data_a_d = sel_a;
                    data_b_d = sel_b;
                    zero_d   = sel_zero;
                    // A bypassed operation never touches the multiplier.
                    state_d  = sel_zero ? S_CAPT : S_CLEAR;
                end
            end

            S_CLEAR: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end

            S_RUN: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_CAPT;
                end
            end

            S_CAPT: begin
                if (zero_q) begin
                    hi_d = '0;
                    lo_d = '0;
                end else begin
                    hi_d = bus.mul_product[63:32];
                    lo_d = bus.mul_product[31:0];
                end
                done0_d = gnt0_q;
                done1_d = gnt1_q;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            lg_q     <= 1'b1;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lg_q     <= lg_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.gnt0       = gnt0_q;
    assign bus.gnt1       = gnt1_q;
    assign bus.done0      = done0_q;
    assign bus.done1      = done1_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
    assign bus.mul_dataA  = data_a_q;
    assign bus.mul_dataB  = data_b_q;
    assign bus.mul_signal = (state_q == S_RUN) ? SIG_MULTU : SIG_OUT;
    // Reset reaches the multiplier combinationally so its product is
    // cleared for as long as reset is held.
    assign bus.mul_reset  = reset | (state_q == S_CLEAR);

endmodule

// File: tb/tb_mult_sched.sv
module tb_mult_sched;

    localparam logic [5:0] SIG_MULTU = 6'b011001;
    localparam logic [5:0] SIG_OUT   = 6'b111111;

`ifdef MULT_SCHED_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    int unsigned cyc    = 0;

    mult_sched_if bus ();

    mult_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Multiplier stand-in: clears on mul_reset, then adds one shifted
    // partial product per MULTU cycle; the product is only right after
    // exactly 32 iterations on the latched operands.
    logic [63:0] acc_q = '0;
    logic [5:0]  it_q  = '0;

    always @(posedge clk) begin
        if (bus.mul_reset) begin
            acc_q <= '0;
            it_q  <= '0;
        end else if (bus.mul_signal == SIG_MULTU && it_q < 6'd32) begin
            if (bus.mul_dataB[it_q[4:0]])
                acc_q <= acc_q + ({32'd0, bus.mul_dataA} << it_q[4:0]);
            it_q <= it_q + 6'd1;
        end
    end

    assign bus.mul_product = acc_q;

    // Reference model: an operation is a countdown of edges from the grant
    // edge to the capture edge (34, or 1 when bypassed); the result is a*b.
    bit          m_act  = 1'b0;
    bit          m_port = 1'b0;
    bit          m_lg   = 1'b1;
    bit          m_byp  = 1'b0;
    int          m_left = 0;
    logic [31:0] m_a    = '0;
    logic [31:0] m_b    = '0;
    logic [63:0] m_prod = '0;
    logic [63:0] m_res  = '0;
    logic [1:0]  m_done = '0;

    always @(posedge clk) begin
        cyc++;
        m_done = 2'b00;
        if (reset) begin
            m_act  = 1'b0;
            m_lg   = 1'b1;
            m_byp  = 1'b0;
            m_left = 0;
            m_a    = '0;
            m_b    = '0;
            m_res  = '0;
        end else if (m_act) begin
            m_left--;
            if (m_left == 0) begin
                m_res          = m_prod;
                m_act          = 1'b0;
                m_done[m_port] = 1'b1;
            end
        end else if (bus.req0 || bus.req1) begin
            m_port = (bus.req0 && bus.req1) ? ~m_lg : bus.req1;
            m_lg   = m_port;
            m_a    = m_port ? bus.a1 : bus.a0;
            m_b    = m_port ? bus.b1 : bus.b0;
            m_act  = 1'b1;
            m_byp  = BYPASS && (m_a == 0 || m_b == 0);
            m_left = m_byp ? 1 : 34;
            m_prod = m_byp ? 64'd0 : 64'(m_a) * 64'(m_b);
        end
    end

    always @(negedge clk) begin
        logic [5:0] exp_ctl;
        logic [5:0] exp_sig;
        exp_ctl = {m_act && !m_port, m_act && m_port, m_done[0], m_done[1], m_act,
                   reset || (m_act && !m_byp && m_left == 34)};
        exp_sig = (m_act && !m_byp && m_left >= 2 && m_left <= 33) ? SIG_MULTU : SIG_OUT;
        chk("ctl", {58'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.mul_reset},
            {58'd0, exp_ctl});
        chk("hilo", {bus.hi, bus.lo}, m_res);
        chk("opnd", {bus.mul_dataA, bus.mul_dataB}, {m_a, m_b});
        chk("msig", {58'd0, bus.mul_signal}, {58'd0, exp_sig});
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Counts negedges until the port's done is seen (bounded by budget);
    // returns positioned just after that negedge so the caller can drop req.
    task automatic wait_done(input string tag, input bit p, input int budget, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < budget) begin
            @(negedge clk);
            lat++;
            seen = p ? bus.done1 : bus.done0;
        end
        #1;
        chk(tag, {63'd0, seen}, 64'd1);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          lat;
        int          lat1;
        logic [31:0] ta;
        logic [31:0] tb;
        bit          d0;
        bit          d1;
        bit          hold0;
        bit          hold1;

        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.a0   = '0;
        bus.b0   = '0;
        bus.a1   = '0;
        bus.b1   = '0;
        hold0    = 1'b0;
        hold1    = 1'b0;

        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);

        // Port 0, small operands
        bus.a0 = 32'd12345; bus.b0 = 32'd6789; bus.req0 = 1'b1;
        wait_done("tp1_done", 1'b0, 40, lat);
        chk("tp1_lat", 64'(lat), 64'd35);
        chk("tp1_prod", {bus.hi, bus.lo}, 64'd83810205);
        bus.req0 = 1'b0;
        tick();
        chk("tp1_busy", {63'd0, bus.busy}, 64'd0);

        // Port 1, all-ones operands
        bus.a1 = 32'hFFFF_FFFF; bus.b1 = 32'hFFFF_FFFF; bus.req1 = 1'b1;
        wait_done("tp2_done", 1'b1, 40, lat);
        chk("tp2_lat", 64'(lat), 64'd35);
        chk("tp2_prod", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        bus.req1 = 1'b0;

        // Simultaneous requests right after reset: port 0 first
        reset = 1'b1; tick(); reset = 1'b0; tick();
        bus.a0 = 32'd3;  bus.b0 = 32'd7;
        bus.a1 = 32'd11; bus.b1 = 32'd13;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        wait_done("tp3_done0", 1'b0, 40, lat);
        chk("tp3_lat0", 64'(lat), 64'd35);
        chk("tp3_prod0", {bus.hi, bus.lo}, 64'd21);
        bus.req0 = 1'b0;
        repeat (5) tick();
        chk("tp3_gnt1", {62'd0, bus.gnt0, bus.gnt1}, 64'd1);
        bus.a0 = 32'd5; bus.b0 = 32'd9; bus.req0 = 1'b1;
        wait_done("tp3_done1", 1'b1, 40, lat1);
        chk("tp3_lat1", 64'(lat1 + 5), 64'd35);
        chk("tp3_prod1", {bus.hi, bus.lo}, 64'd143);
        bus.req1 = 1'b0;
        wait_done("tp3_done0b", 1'b0, 40, lat);
        chk("tp3_lat0b", 64'(lat), 64'd35);
        chk("tp3_prod0b", {bus.hi, bus.lo}, 64'd45);
        bus.req0 = 1'b0;

        // Reset at E20 of an operation; held req is re-granted
        ta = $urandom | 32'd1; tb = $urandom | 32'd1;
        bus.a0 = ta; bus.b0 = tb; bus.req0 = 1'b1;
        repeat (20) tick();
        reset = 1'b1;
        tick();
        chk("tp4_gnt", {62'd0, bus.gnt0, bus.gnt1}, 64'd0);
        chk("tp4_busy", {63'd0, bus.busy}, 64'd0);
        chk("tp4_hilo", {bus.hi, bus.lo}, 64'd0);
        reset = 1'b0;
        tick();
        chk("tp4_regnt", {62'd0, bus.gnt0, bus.gnt1}, 64'd2);
        wait_done("tp4_done", 1'b0, 40, lat);
        chk("tp4_lat", 64'(lat), 64'd34);
        chk("tp4_prod", {bus.hi, bus.lo}, 64'(ta) * 64'(tb));
        bus.req0 = 1'b0;

        // Zero operand
        bus.a0 = 32'd0; bus.b0 = 32'd5; bus.req0 = 1'b1;
        wait_done("tp5_done", 1'b0, 40, lat);
        chk("tp5_lat", 64'(lat), BYPASS ? 64'd2 : 64'd35);
        chk("tp5_prod", {bus.hi, bus.lo}, 64'd0);
        bus.req0 = 1'b0;

        // req dropped at E10 does not abort
        ta = $urandom; tb = $urandom;
        bus.a0 = ta; bus.b0 = tb; bus.req0 = 1'b1;
        repeat (10) tick();
        bus.req0 = 1'b0;
        wait_done("tp6_done", 1'b0, 40, lat);
        chk("tp6_lat", 64'(lat + 10), 64'd35);
        chk("tp6_prod", {bus.hi, bus.lo}, 64'(ta) * 64'(tb));

        // Randomized traffic with occasional mid-operation drops and resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            d0 = bus.done0;
            d1 = bus.done1;
            #1;
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                hold0 = 1'b0;
                hold1 = 1'b0;
            end
            if (d0) begin
                bus.req0 = 1'b0; hold0 = 1'b0;
            end else if (!bus.req0 && !hold0 && $urandom_range(0, 3) == 0) begin
                bus.req0 = 1'b1;
            end else if (bus.req0 && bus.gnt0 && $urandom_range(0, 39) == 0) begin
                bus.req0 = 1'b0; hold0 = 1'b1;
            end
            if (d1) begin
                bus.req1 = 1'b0; hold1 = 1'b0;
            end else if (!bus.req1 && !hold1 && $urandom_range(0, 3) == 0) begin
                bus.req1 = 1'b1;
            end else if (bus.req1 && bus.gnt1 && $urandom_range(0, 39) == 0) begin
                bus.req1 = 1'b0; hold1 = 1'b1;
            end
            bus.a0 = rnd_opnd();
            bus.b0 = rnd_opnd();
            bus.a1 = rnd_opnd();
            bus.b1 = rnd_opnd();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
